// File: rtl/log_event_arbiter.sv
// Log event arbiter: per-source one-entry pending registers, round-robin
// arbitration into a small output FIFO, and a saturating drop counter.
//
// Handshake: a record is presented while log_valid_o is high and is consumed
// on a rising edge where log_valid_o && log_ready_i; until then log_src_o,
// log_pc_o and log_hart_o hold the same head record.
module log_event_arbiter #(
    parameter int NUM_SRC = 3,
    parameter int DEPTH   = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_SRC-1:0]         src_valid_i,
    input  logic [NUM_SRC*32-1:0]      src_pc_i,
    input  logic [31:0]                hart_id_i,
    output logic                       log_valid_o,
    input  logic                       log_ready_i,
    output logic [$clog2(NUM_SRC)-1:0] log_src_o,
    output logic [31:0]                log_pc_o,
    output logic [3:0]                 log_hart_o,
    output logic [15:0]                drop_cnt_o,
    output logic                       overflow_o,
    input  logic                       clear_i
);
    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Pending entries and round-robin pointer (index of the last winner)
    logic [NUM_SRC-1:0] pend_q;
    logic [31:0]        pend_pc_q   [NUM_SRC];
    logic [3:0]         pend_hart_q [NUM_SRC];
    logic [SRC_W-1:0]   rr_ptr_q;

    // Output FIFO storage and bookkeeping
    logic [SRC_W-1:0]   fifo_src_q  [DEPTH];
    logic [31:0]        fifo_pc_q   [DEPTH];
    logic [3:0]         fifo_hart_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;

    // Drop statistics
    logic [15:0]        drop_cnt_q;
    logic [15:0]        drop_cnt_d;
    logic               overflow_q;
    logic               overflow_d;

    logic [SRC_W:0]     cand;
    logic               gnt_found;
    logic [SRC_W-1:0]   gnt_idx;
    logic               grant;
    logic               push;
    logic               pop;
    logic               full;
    logic [NUM_SRC-1:0] gnt_oh;
    logic [NUM_SRC-1:0] drop_vec;
    logic [3:0]         drop_num;
    logic [16:0]        drop_sum;
    logic               unused_hart;

    // Only the low hart bits are recorded
    assign unused_hart = ^hart_id_i[31:4];

    assign log_valid_o = (count_q != '0);
    assign full        = (count_q == CNT_W'(DEPTH));
    assign pop         = log_valid_o && log_ready_i;
    assign grant       = gnt_found && (!full || pop);
    assign push        = grant;

    assign log_src_o   = fifo_src_q[rd_ptr_q];
    assign log_pc_o    = fifo_pc_q[rd_ptr_q];
    assign log_hart_o  = fifo_hart_q[rd_ptr_q];
    assign drop_cnt_o  = drop_cnt_q;
    assign overflow_o  = overflow_q;

    // Round-robin search: start one past the last winner, first set pend wins
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            cand = {1'b0, rr_ptr_q} + (SRC_W+1)'(i);
            if (cand >= (SRC_W+1)'(NUM_SRC)) begin
                cand = cand - (SRC_W+1)'(NUM_SRC);
            end
            if (!gnt_found && pend_q[cand[SRC_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[SRC_W-1:0];
            end
        end
    end

    // Grant one-hot, drop detection and per-cycle drop count
    always_comb begin
        gnt_oh   = '0;
        drop_vec = '0;
        drop_num = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            gnt_oh[k]   = grant && (gnt_idx == SRC_W'(k));
            drop_vec[k] = src_valid_i[k] && pend_q[k] && !gnt_oh[k];
            drop_num    = drop_num + 4'(drop_vec[k]);
        end
    end

    // Pending registers: capture when free or being granted, else drop
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pend_q   <= '0;
            rr_ptr_q <= SRC_W'(NUM_SRC - 1);
            for (int k = 0; k < NUM_SRC; k++) begin
                pend_pc_q[k]   <= '0;
                pend_hart_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (src_valid_i[k] && (!pend_q[k] || gnt_oh[k])) begin
                    pend_q[k]      <= 1'b1;
                    pend_pc_q[k]   <= src_pc_i[32*k +: 32];
                    pend_hart_q[k] <= hart_id_i[3:0];
                end else if (gnt_oh[k]) begin
                    pend_q[k] <= 1'b0;
                end
            end
            if (grant) begin
                rr_ptr_q <= gnt_idx;
            end
        end
    end

    // FIFO occupancy next state; push and pop together leave it unchanged
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO storage and pointers; storage cleared so outputs read zero after reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int d = 0; d < DEPTH; d++) begin
                fifo_src_q[d]  <= '0;
                fifo_pc_q[d]   <= '0;
                fifo_hart_q[d] <= '0;
            end
        end else begin
            if (push) begin
                fifo_src_q[wr_ptr_q]  <= gnt_idx;
                fifo_pc_q[wr_ptr_q]   <= pend_pc_q[gnt_idx];
                fifo_hart_q[wr_ptr_q] <= pend_hart_q[gnt_idx];
                wr_ptr_q              <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Drop counter next state: clear wins, otherwise saturating add
    always_comb begin
        drop_sum = {1'b0, drop_cnt_q} + 17'(drop_num);
        if (clear_i) begin
            drop_cnt_d = '0;
            overflow_d = 1'b0;
        end else begin
            drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            overflow_d = overflow_q || (drop_num != '0);
        end
    end

    // Drop statistics registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: doc/log_event_arbiter.md
LOG_EVENT_ARBITER -- requirements
Module: cv32e41p_log_event_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 3, SHALL set the number of event requesters (legal range 2..8).
REQ-002 Parameter DEPTH, default 4, SHALL set the output FIFO depth (power of two, 2..16).
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  SHALL be the synchronous, active-low reset, sampled on rising clk_i.
REQ-005 src_valid_i  input  NUM_SRC  SHALL carry per-source single-cycle event strobes (e.g. illegal insn, ecall, debug entry).
REQ-006 src_pc_i  input  NUM_SRC*32  SHALL carry the PC for each source; source k occupies bits [32k+31:32k].
REQ-007 hart_id_i  input  32  SHALL carry the hart id; only bits [3:0] are recorded.
REQ-008 log_valid_o  output  1  SHALL indicate that a log record is presented.
REQ-009 log_ready_i  input  1  SHALL indicate that the consumer accepts the record.
REQ-010 log_src_o  output  $clog2(NUM_SRC)  SHALL give the source index of the presented record.
REQ-011 log_pc_o  output  32, and log_hart_o  output  4, SHALL give the PC and hart of the presented record.
REQ-012 drop_cnt_o  output  16  SHALL give the saturating count of dropped events.
REQ-013 overflow_o  output  1  SHALL be a sticky flag set on any drop.
REQ-014 clear_i  input  1  SHALL zero drop_cnt_o and overflow_o.

Function
REQ-015 Each source SHALL own a one-entry pending register {pend, pc, hart[3:0]}, loaded when src_valid_i[k] is high.
REQ-016 Arbitration SHALL be round-robin over set pend bits: search from rr_ptr+1 modulo NUM_SRC; the first set bit wins.
REQ-017 A grant SHALL occur only when the FIFO is not full, or is full and a pop happens in the same cycle.
REQ-018 On a grant, the winner's pending entry SHALL be pushed into the FIFO, its pend cleared, and rr_ptr set to the winner index.
REQ-019 At most one grant SHALL occur per cycle.
REQ-020 If src_valid_i[k] is high while pend[k] is set and k is not granted that cycle, the new event SHALL be dropped and the pending entry kept unchanged.
REQ-021 If src_valid_i[k] is high in the same cycle k is granted, the new event SHALL be captured (pend stays 1), with no drop.
REQ-022 Latency: a strobe in cycle N with an idle arbiter and empty FIFO SHALL give log_valid_o=1 in cycle N+2.
REQ-023 A pop SHALL occur when log_valid_o && log_ready_i; the head SHALL advance on the next edge.
REQ-024 log_valid_o SHALL equal "FIFO not empty"; outputs SHALL hold stable while log_valid_o && !log_ready_i.
REQ-025 The FIFO SHALL use wrapping read/write pointers of $clog2(DEPTH) bits plus a count of $clog2(DEPTH)+1 bits; a simultaneous push and pop SHALL leave the count unchanged.
REQ-026 drop_cnt_o SHALL add the number of drops in a cycle (0..NUM_SRC), saturating at 16'hFFFF.
REQ-027 overflow_o SHALL set on any drop.
REQ-028 clear_i SHALL take priority over increments in the same cycle, so drops in that cycle are not counted.

Reset
REQ-029 With rst_ni low at a rising edge: pend=0, FIFO empty (pointers and count 0), rr_ptr=NUM_SRC-1 (source 0 has first priority), drop_cnt_o=0, overflow_o=0.
REQ-030 During and after reset: log_valid_o=0, log_src_o=0, log_pc_o=0, log_hart_o=0 until the first push.
REQ-031 Reset asserted mid-operation SHALL discard all pending and queued records without emitting them.

Verification
REQ-032 Single event: src_valid_i=3'b010, pc1=0x0000_1000, hart=5, ready=1 -> two cycles later log_valid_o=1, src=1, pc=0x1000, hart=5 for exactly 1 cycle.
REQ-033 Simultaneous events: src_valid_i=3'b111 for one cycle, ready=1 -> records emitted in order src 0,1,2 on consecutive cycles; drop_cnt_o=0.
REQ-034 Backpressure: ready=0, DEPTH=4, src0 strobed every cycle for 8 cycles -> FIFO holds 4 records, pending holds a 5th, drop_cnt_o=3, overflow_o=1, outputs stable.
REQ-035 Full with pop: FIFO full and pend[2]=1, ready=1 for one cycle -> one pop and one push in the same cycle, count stays 4, no drop.
REQ-036 Saturation and clear: preload drop_cnt=16'hFFFE, cause 2 drops in one cycle -> 16'hFFFF; then clear_i=1 together with a drop -> drop_cnt_o=0, overflow_o=0.
REQ-037 Reset mid-stream: 3 records queued, rst_ni=0 for one cycle -> log_valid_o=0 on the next cycle and no stale record appears afterwards.
